alu_seq16: RTL
==============

# alu_seq16

Multi-cycle sequencer for the shared 8-bit ALU. It accepts one 8- or 16-bit arithmetic command per handshake and drives the combinational 8-bit ALU one byte per cycle, chaining carry and borrow between passes. It owns the architectural flag register F (Z=7, N=6, H=5, C=4, bits 3:0 always 0). It sits between the CPU decode/control FSM and the ALU datapath.

## Interface
- Reset: one clock; reset is asynchronous and active-high (`clk`, `reset`).
- Parameter `RESET_FLAGS`, default 8'h00: value of F after reset. Bits 3:0 are ignored and forced to 0.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: command request; sampled only in IDLE.
- `cmd` in 3: 0=OP8, 1=ADD16, 2=SUB16, 3=INC16, 4=DEC16, 5-7=NOP.
- `op8` in 4: ALU opcode used by OP8.
- `opA`, `opB` in 16 each: operands. OP8 uses [7:0] only; INC16/DEC16 ignore `opB`.
- `flagsLoad` in 1: load F from `flagsIn`; honoured in IDLE only.
- `flagsIn` in 8: new F value; bits 3:0 are discarded.
- `ready` out 1: 1 in IDLE.
- `busy` out 1: 1 in LO and HI.
- `done` out 1: 1-cycle pulse in DONE.
- `result` out 16: registered result; held until the next accepted command.
- `flags` out 8: F register.
- `aluA`, `aluB` out 8 each: ALU operands.
- `aluOp` out 4: ALU opcode (ADD=0000, ADC=0001, SUB=0010, SBC=0011).
- `aluCin` out 1: ALU carry/borrow in.
- `aluRes` in 8: ALU result.
- `aluFlags` in 8: ALU flags.

## Operation
- **States:** IDLE → LO → HI → DONE → IDLE. OP8 skips HI (LO → DONE). NOP goes IDLE → DONE.
- **Accept:** in IDLE, `start`=1 and `flagsLoad`=0 latches `cmd`, `op8`, `opA`, `opB`.
  - If `flagsLoad`=1, it takes priority: F ← {`flagsIn`[7:4], 4'h0} and `start` is ignored that cycle.
- **ALU drive:** the ALU is combinational. The sequencer drives it from state and captures `aluRes`/`aluFlags` at the end of LO and at the end of HI.
  - LO pass: `aluA`=A[7:0], `aluB`=B[7:0] (or 8'h01 for INC16/DEC16).
  - HI pass: `aluA`=A[15:8], `aluB`=B[15:8] (or 8'h00).
  - `aluCin` in HI = captured LO carry (`aluFlags`[4]).
  - IDLE/DONE: `aluA`=`aluB`=0, `aluOp`=ADD, `aluCin`=0.
- **Per-command ops:**
  - OP8: LO `aluOp`=`op8`, `aluCin`=F.C. Result={8'h00, `aluRes`}. F ← {`aluFlags`[7:4], 4'h0}.
  - ADD16: LO ADD, HI ADC. Z preserved, N=0, H/C from the HI pass.
  - SUB16: LO SUB, HI SBC. Z=(16-bit result==0), N=1, H/C from the HI pass.
  - INC16: LO ADD, HI ADC. F unchanged.
  - DEC16: LO SUB, HI SBC. F unchanged.
  - NOP: result=16'h0000, F unchanged.
- **Result register:** LO captures `result`[7:0]; HI captures `result`[15:8]. OP8 clears `result`[15:8] in LO.
- **Wrap-around:** 16-bit results wrap modulo 2^16; carry out is reported only via C.
- **While busy:** `start` and `flagsLoad` outside IDLE are ignored, not queued. Operand inputs may change after acceptance without effect.

## Timing
- **Reset values:** state=IDLE, `ready`=1, `busy`=0, `done`=0, `result`=16'h0000, `flags`={`RESET_FLAGS`[7:4], 4'h0}. ALU outputs take their IDLE values.
- **Latency:** accept at edge 0.
  - 16-bit commands: LO during cycle 1, HI during cycle 2, `done`=1 during cycle 3.
  - OP8: `done` in cycle 2.
  - NOP: `done` in cycle 1.
- **Output validity:** `result` and `flags` are valid and stable when `done`=1, and hold thereafter.
- **Throughput:** `ready` returns the cycle after DONE. Throughput is one 16-bit command per 4 cycles.
- **Reset mid-operation:** returns to IDLE immediately with the reset values above. No partial result or flag update survives.

## Test plan
- **ADD16:** F=8'h80, ADD16 `opA`=16'h0FFF, `opB`=16'h0001 → `result`=16'h1000, F=8'hA0 (Z kept, H=1, C=0), `done` 3 cycles after accept.
- **SUB16:** SUB16 `opA`=16'h1000, `opB`=16'h0001 → `result`=16'h0FFF, F=8'h60. Then SUB16 16'h1234−16'h1234 → 16'h0000, F=8'hC0.
- **DEC16/INC16:** F=8'h50, DEC16 `opA`=16'h0000 → 16'hFFFF, F stays 8'h50. INC16 16'hFFFF → 16'h0000, F stays 8'h50.
- **OP8:** `flagsLoad` 8'h1F → F=8'h10. OP8 ADC `opA`=8'hFF, `opB`=8'h00 → `result`=16'h0000, F=8'hB0, `done` 2 cycles after accept.
- **Ignored requests:** `start` and `flagsLoad` asserted during LO/HI are ignored; `result` and F reflect only the first command.
- **Reset:** `reset` asserted in HI of an ADD16 → outputs return to reset values asynchronously, with no `done` pulse.

Source files
------------

// File: rtl/alu_seq16.sv
// Multi-cycle sequencer for the shared 8-bit ALU: runs 8/16-bit commands one byte per
// cycle, chains carry/borrow between passes and owns the architectural flag register F.
module alu_seq16 #(
  parameter logic [7:0] RESET_FLAGS = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  cmd,
  input  logic [3:0]  op8,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic        flagsLoad,
  input  logic [7:0]  flagsIn,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  flags,
  output logic [7:0]  aluA,
  output logic [7:0]  aluB,
  output logic [3:0]  aluOp,
  output logic        aluCin,
  input  logic [7:0]  aluRes,
  input  logic [7:0]  aluFlags
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [2:0] CMD_OP8   = 3'd0;
  localparam logic [2:0] CMD_ADD16 = 3'd1;
  localparam logic [2:0] CMD_SUB16 = 3'd2;
  localparam logic [2:0] CMD_INC16 = 3'd3;
  localparam logic [2:0] CMD_DEC16 = 3'd4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADC = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0011;

  localparam logic [7:0] FLAGS_RST = {RESET_FLAGS[7:4], 4'h0};

  state_t      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [3:0]  op8_q, op8_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  flags_q, flags_d;
  logic        carry_q, carry_d;

  logic        accept;
  logic        is_step;   // INC16/DEC16 use a constant step instead of opB
  logic        is_sub;

  assign accept  = start && !flagsLoad;
  assign is_step = (cmd_q == CMD_INC16) || (cmd_q == CMD_DEC16);
  assign is_sub  = (cmd_q == CMD_SUB16) || (cmd_q == CMD_DEC16);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (cmd > CMD_DEC16) ? S_DONE : S_LO;
      S_LO:   state_d = (cmd_q == CMD_OP8) ? S_DONE : S_HI;
      S_HI:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == S_IDLE);
    busy   = (state_q == S_LO) || (state_q == S_HI);
    done   = (state_q == S_DONE);
    aluA   = 8'h00;
    aluB   = 8'h00;
    aluOp  = OP_ADD;
    aluCin = 1'b0;
    unique case (state_q)
      S_LO: begin
        aluA = a_q[7:0];
        aluB = is_step ? 8'h01 : b_q[7:0];
        if (cmd_q == CMD_OP8) begin
          aluOp  = op8_q;
          aluCin = flags_q[4];
        end else begin
          aluOp  = is_sub ? OP_SUB : OP_ADD;
        end
      end
      S_HI: begin
        aluA   = a_q[15:8];
        aluB   = is_step ? 8'h00 : b_q[15:8];
        aluOp  = is_sub ? OP_SBC : OP_ADC;
        aluCin = carry_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_d    = cmd_q;
    op8_d    = op8_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    carry_d  = carry_q;
    unique case (state_q)
      S_IDLE: begin
        if (flagsLoad) begin
          flags_d = {flagsIn[7:4], 4'h0};
        end else if (start) begin
          cmd_d = cmd;
          op8_d = op8;
          a_d   = opA;
          b_d   = opB;
          if (cmd > CMD_DEC16) result_d = 16'h0000;
        end
      end
      S_LO: begin
        result_d[7:0] = aluRes;
        carry_d       = aluFlags[4];
        if (cmd_q == CMD_OP8) begin
          result_d[15:8] = 8'h00;
          flags_d        = {aluFlags[7:4], 4'h0};
        end
      end
      S_HI: begin
        result_d[15:8] = aluRes;
        // ADD16 keeps the old Z; SUB16 derives Z from the whole 16-bit difference
        if (cmd_q == CMD_ADD16)
          flags_d = {flags_q[7], 1'b0, aluFlags[5:4], 4'h0};
        else if (cmd_q == CMD_SUB16)
          flags_d = {({aluRes, result_q[7:0]} == 16'h0000), 1'b1, aluFlags[5:4], 4'h0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q    <= 3'd0;
      op8_q    <= 4'd0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      result_q <= 16'h0000;
      flags_q  <= FLAGS_RST;
      carry_q  <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      op8_q    <= op8_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule
